// File: rtl/traffic_pkg.sv
// Shared lamp codes, controller state encoding and way-index width helper
// for the multi-way traffic controller.
package traffic_pkg;

  localparam logic [1:0] LAMP_OFF    = 2'd0;
  localparam logic [1:0] LAMP_GREEN  = 2'd1;
  localparam logic [1:0] LAMP_YELLOW = 2'd2;
  localparam logic [1:0] LAMP_RED    = 2'd3;

  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_YELLOW = 2'd1,
    S_ALLRED = 2'd2,
    S_FLASH  = 2'd3
  } state_e;

  // Way index width; never narrower than one bit.
  function automatic int unsigned way_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_next_way.sv
// Combinational round-robin finder: first requesting way after cur_way_i,
// searching upward with wrap-around (cur_way_i itself is checked last).
module rr_next_way
  import traffic_pkg::*;
#(
  parameter  int unsigned N_WAYS = 4,
  localparam int unsigned WAY_W  = way_w(N_WAYS)
) (
  input  logic [WAY_W-1:0]  cur_way_i,
  input  logic [N_WAYS-1:0] req_i,
  output logic [WAY_W-1:0]  next_way_o,
  output logic              any_req_o
);

  always_comb begin
    logic              found;
    int unsigned       idx;
    logic [N_WAYS-1:0] rot;
    found      = 1'b0;
    idx        = 0;
    rot        = '0;
    next_way_o = cur_way_i;
    any_req_o  = |req_i;
    for (int unsigned k = 1; k <= N_WAYS; k++) begin
      idx = (32'(cur_way_i) + k) % N_WAYS;
      rot = req_i >> idx;
      if (!found && rot[0]) begin
        next_way_o = WAY_W'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_way_traffic_ctrl.sv
// N-way intersection signal controller: green/yellow/all-red sequencing with
// actuated skip and rest-in-green, emergency pre-emption and night flash.
module multi_way_traffic_ctrl
  import traffic_pkg::*;
#(
  parameter  int unsigned N_WAYS        = 4,
  parameter  int unsigned GREEN_CYCLES  = 8,
  parameter  int unsigned YELLOW_CYCLES = 3,
  parameter  int unsigned ALLRED_CYCLES = 2,
  parameter  int unsigned FLASH_HALF    = 4,
  localparam int unsigned WAY_W         = way_w(N_WAYS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  actuated,
  input  logic [N_WAYS-1:0]     req,
  input  logic                  emerg_req,
  input  logic [WAY_W-1:0]      emerg_way,
  input  logic                  flash_en,
  output logic [2*N_WAYS-1:0]   lights,
  output logic [WAY_W-1:0]      active_way,
  output logic                  emerg_ack
);

  localparam int unsigned MAX_GY  = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES;
  localparam int unsigned MAX_AF  = (ALLRED_CYCLES > FLASH_HALF) ? ALLRED_CYCLES : FLASH_HALF;
  localparam int unsigned MAX_DUR = (MAX_GY > MAX_AF) ? MAX_GY : MAX_AF;
  localparam int unsigned CNT_W   = $clog2(MAX_DUR) + 1;

  localparam logic [CNT_W-1:0] G_LAST  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALLRED_CYCLES - 1);
  localparam logic [CNT_W-1:0] F_LAST  = CNT_W'(FLASH_HALF - 1);

  state_e             state_q, state_d;
  logic [WAY_W-1:0]   cur_way_q, cur_way_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               flash_ph_q, flash_ph_d;

  logic [WAY_W-1:0]   rr_next;
  logic               any_req;
  logic               emerg_vld;
  logic               other_req;
  logic [WAY_W-1:0]   inc_way;

  // Out-of-range emergency targets are treated as no request.
  assign emerg_vld = emerg_req && (32'(emerg_way) < N_WAYS);
  assign other_req = |(req & ~(N_WAYS'(1) << cur_way_q));
  assign inc_way   = (cur_way_q == WAY_W'(N_WAYS - 1)) ? '0 : cur_way_q + WAY_W'(1);

  rr_next_way #(
    .N_WAYS (N_WAYS)
  ) u_rr_next_way (
    .cur_way_i  (cur_way_q),
    .req_i      (req),
    .next_way_o (rr_next),
    .any_req_o  (any_req)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_GREEN;
      cur_way_q  <= '0;
      cnt_q      <= '0;
      flash_ph_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_way_q  <= cur_way_d;
      cnt_q      <= cnt_d;
      flash_ph_q <= flash_ph_d;
    end
  end

  always_comb begin : next_state
    state_d    = state_q;
    cur_way_d  = cur_way_q;
    cnt_d      = cnt_q;
    flash_ph_d = flash_ph_q;
    unique case (state_q)
      S_GREEN: begin
        if ((emerg_vld && emerg_way != cur_way_q) || (flash_en && !emerg_vld)) begin
          state_d = S_YELLOW;
          cnt_d   = '0;
        end else if (emerg_vld) begin
          cnt_d = '0;
        end else if (cnt_q == G_LAST) begin
          // Rest in green (count saturated) while nobody else is waiting.
          if (!(actuated && !other_req)) begin
            state_d = S_YELLOW;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_YELLOW: begin
        if (cnt_q == Y_LAST) begin
          state_d = S_ALLRED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ALLRED: begin
        if (cnt_q == AR_LAST) begin
          cnt_d = '0;
          if (emerg_vld) begin
            state_d   = S_GREEN;
            cur_way_d = emerg_way;
          end else if (flash_en) begin
            state_d    = S_FLASH;
            flash_ph_d = 1'b0;
          end else begin
            state_d   = S_GREEN;
            cur_way_d = (actuated && any_req) ? rr_next : inc_way;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FLASH: begin
        if (!flash_en || emerg_vld) begin
          state_d    = S_ALLRED;
          cnt_d      = '0;
          flash_ph_d = 1'b0;
        end else if (cnt_q == F_LAST) begin
          cnt_d      = '0;
          flash_ph_d = ~flash_ph_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin : outputs
    logic [1:0] code;
    code       = LAMP_RED;
    lights     = '0;
    active_way = cur_way_q;
    for (int unsigned i = 0; i < N_WAYS; i++) begin
      code = LAMP_RED;
      unique case (state_q)
        S_GREEN:  if (WAY_W'(i) == cur_way_q) code = LAMP_GREEN;
        S_YELLOW: if (WAY_W'(i) == cur_way_q) code = LAMP_YELLOW;
        S_FLASH:  code = flash_ph_q ? LAMP_OFF : LAMP_YELLOW;
        default:  code = LAMP_RED;
      endcase
      lights[2*i +: 2] = code;
    end
    emerg_ack = (state_q == S_GREEN) && emerg_vld && (emerg_way == cur_way_q);
  end

endmodule
